// File: rtl/video_vram_writer.sv
// Raster pixel stream to vram write port, with a full-frame clear sequencer.
// Optional frame_cnt/err_cnt outputs are enabled by VIDEO_VRAM_WRITER_STATS_EN.
module video_vram_writer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int IMAW   = 19,
  parameter int IMDW   = 8
) (
  input  logic            clk,
  input  logic            clk_en,
  input  logic            rst,
  input  logic            clr_req,
  input  logic [IMDW-1:0] clr_dat,
  output logic            busy,
  output logic            clr_done,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [IMDW-1:0] pix_dat,
  input  logic            pix_last,
  output logic            frame_done,
  output logic            err_sync,
  output logic            vram_clk_en_w,
  output logic            vram_we,
  output logic [IMAW-1:0] vram_adr_w,
  output logic [IMDW-1:0] vram_dat_w
`ifdef VIDEO_VRAM_WRITER_STATS_EN
  ,
  output logic [15:0]     frame_cnt,
  output logic [7:0]      err_cnt
`endif
);

  localparam int NPIXELS = WIDTH * HEIGHT;
  localparam logic [IMAW-1:0] LAST = IMAW'(NPIXELS - 1);

  typedef enum logic {ST_STREAM, ST_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [IMAW-1:0] adr_q, adr_d;
  logic [IMDW-1:0] fill_q, fill_d;
  logic            busy_d, we_d, fd_d, err_d, cd_d;
  logic [IMAW-1:0] adr_w_d;
  logic [IMDW-1:0] dat_w_d;

  assign vram_clk_en_w = clk_en;
  assign pix_ready     = (state_q == ST_STREAM) & ~clr_req & clk_en;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    fill_d  = fill_q;
    busy_d  = busy;
    we_d    = 1'b0;
    adr_w_d = vram_adr_w;
    dat_w_d = vram_dat_w;
    fd_d    = 1'b0;
    err_d   = 1'b0;
    cd_d    = 1'b0;
    case (state_q)
      ST_STREAM: begin
        // A clear request wins over a pixel offered in the same cycle.
        if (clr_req) begin
          state_d = ST_CLEAR;
          fill_d  = clr_dat;
          adr_d   = '0;
          busy_d  = 1'b1;
        end else if (pix_valid) begin
          we_d    = 1'b1;
          adr_w_d = adr_q;
          dat_w_d = pix_dat;
          if (adr_q == LAST) begin
            adr_d = '0;
            fd_d  = 1'b1;
            err_d = ~pix_last;
          end else if (pix_last) begin
            // Early frame marker: resync so the next pixel starts a frame.
            adr_d = '0;
            err_d = 1'b1;
          end else begin
            adr_d = adr_q + IMAW'(1);
          end
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        adr_w_d = adr_q;
        dat_w_d = fill_q;
        if (adr_q == LAST) begin
          state_d = ST_STREAM;
          adr_d   = '0;
          busy_d  = 1'b0;
          cd_d    = 1'b1;
        end else begin
          adr_d = adr_q + IMAW'(1);
        end
      end
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STREAM;
      adr_q      <= '0;
      fill_q     <= '0;
      busy       <= 1'b0;
      clr_done   <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
      vram_we    <= 1'b0;
      vram_adr_w <= '0;
      vram_dat_w <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      fill_q     <= fill_d;
      busy       <= busy_d;
      clr_done   <= cd_d;
      frame_done <= fd_d;
      err_sync   <= err_d;
      vram_we    <= we_d;
      vram_adr_w <= adr_w_d;
      vram_dat_w <= dat_w_d;
    end
  end

`ifdef VIDEO_VRAM_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (clk_en) begin
      if (fd_d) frame_cnt <= frame_cnt + 16'd1;
      if (err_d && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_vram_writer.sv
// Bench for video_vram_writer on an 8x4 frame: frame-position model checked every cycle plus literal spot checks.
module tb_video_vram_writer;
  localparam int NPIX = 32;

  logic       clk = 1'b0;
  logic       clk_en, rst, clr_req, pix_valid, pix_ready, pix_last;
  logic       busy, clr_done, frame_done, err_sync, vram_clk_en_w, vram_we;
  logic [7:0] clr_dat, pix_dat, vram_dat_w;
  logic [4:0] vram_adr_w;
`ifdef VIDEO_VRAM_WRITER_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  video_vram_writer #(.WIDTH(8), .HEIGHT(4), .IMAW(5), .IMDW(8)) dut (
    .clk(clk), .clk_en(clk_en), .rst(rst), .clr_req(clr_req), .clr_dat(clr_dat),
    .busy(busy), .clr_done(clr_done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_dat(pix_dat), .pix_last(pix_last), .frame_done(frame_done), .err_sync(err_sync),
    .vram_clk_en_w(vram_clk_en_w), .vram_we(vram_we), .vram_adr_w(vram_adr_w),
    .vram_dat_w(vram_dat_w)
`ifdef VIDEO_VRAM_WRITER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position within the current frame, or a clear in progress.
  bit         m_init = 1'b0;
  bit         m_clearing;
  int         m_pos, m_fc, m_ec;
  logic [7:0] m_fill;
  logic       e_we, e_fd, e_err, e_cd, e_busy;
  logic [4:0] e_adr;
  logic [7:0] e_dat;
  logic       en_edge, just_rst;

  logic [7:0] mem [NPIX];
  int         n_wr, n_fd, n_err, n_cd, n_busy;

  always @(posedge clk) begin
    en_edge  = clk_en | rst;
    just_rst = rst;
    if (rst) begin
      m_init = 1'b1; m_clearing = 1'b0; m_pos = 0; m_fill = 8'h00;
      e_we = 0; e_fd = 0; e_err = 0; e_cd = 0; e_busy = 0;
      e_adr = '0; e_dat = '0; m_fc = 0; m_ec = 0;
    end else if (clk_en && m_init) begin
      e_we = 0; e_fd = 0; e_err = 0; e_cd = 0;
      if (m_clearing) begin
        e_we = 1; e_adr = 5'(m_pos); e_dat = m_fill;
        if (m_pos == NPIX - 1) begin
          m_clearing = 1'b0; m_pos = 0; e_cd = 1;
        end else m_pos++;
      end else if (clr_req) begin
        m_clearing = 1'b1; m_fill = clr_dat; m_pos = 0;
      end else if (pix_valid) begin
        e_we  = 1; e_adr = 5'(m_pos); e_dat = pix_dat;
        e_fd  = (m_pos == NPIX - 1);
        e_err = (pix_last != e_fd);
        m_pos = (e_fd || pix_last) ? 0 : m_pos + 1;
        if (e_fd) m_fc = (m_fc + 1) % 65536;
        if (e_err && m_ec < 255) m_ec++;
      end
      e_busy = m_clearing;
    end
    #1;
    if (m_init) begin
      chk("busy", busy, e_busy);
      chk("clr_done", clr_done, e_cd);
      chk("frame_done", frame_done, e_fd);
      chk("err_sync", err_sync, e_err);
      chk("vram_we", vram_we, e_we);
      chk("vram_clk_en_w", vram_clk_en_w, clk_en);
      chk("pix_ready", pix_ready, !m_clearing && !clr_req && clk_en);
      if (e_we || just_rst) begin
        chk("vram_adr_w", vram_adr_w, e_adr);
        chk("vram_dat_w", vram_dat_w, e_dat);
      end
`ifdef VIDEO_VRAM_WRITER_STATS_EN
      chk("frame_cnt", frame_cnt, m_fc);
      chk("err_cnt", err_cnt, m_ec);
`endif
      if (en_edge) begin
        if (vram_we) begin mem[vram_adr_w] = vram_dat_w; n_wr++; end
        if (frame_done) n_fd++;
        if (err_sync) n_err++;
        if (clr_done) n_cd++;
        if (busy) n_busy++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; clk_en = 1; clr_req = 0; pix_valid = 0; pix_last = 0;
    @(negedge clk);
    rst = 0;
    n_wr = 0; n_fd = 0; n_err = 0; n_cd = 0; n_busy = 0;
    for (int j = 0; j < NPIX; j++) mem[j] = 8'h00;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    @(negedge clk);
    pix_valid = 1; pix_dat = d; pix_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 0; pix_last = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, c, bad;
    rst = 1; clk_en = 1; clr_req = 0; clr_dat = 0; pix_valid = 0; pix_dat = 0; pix_last = 0;

    // Continuous full frame, then wrap to address 0
    do_reset();
    chk("reset vram_we", vram_we, 0);
    for (int i = 0; i < NPIX; i++) send(8'(i + 100), i == NPIX - 1);
    idle(3);
    chk("t1 writes", n_wr, 32);
    chk("t1 frame_done count", n_fd, 1);
    chk("t1 err count", n_err, 0);
    chk("t1 mem0", mem[0], 100);
    chk("t1 mem31", mem[31], 131);
    send(8'd200, 0);
    idle(2);
    chk("t1 wrap mem0", mem[0], 200);

    // clk_en toggling with random valid gaps
    do_reset();
    k = 0; c = 0;
    while (k < NPIX && c < 2000) begin
      @(negedge clk);
      clk_en    = (c % 2 == 0);
      pix_valid = ($urandom_range(0, 2) != 0);
      pix_dat   = 8'(k + 100);
      pix_last  = (k == NPIX - 1);
      if (pix_valid && clk_en) k++;
      c++;
    end
    chk("t2 pixels sent", k, 32);
    @(negedge clk);
    clk_en = 1; pix_valid = 0; pix_last = 0;
    idle(3);
    bad = 0;
    for (int j = 0; j < NPIX; j++) if (mem[j] !== 8'(j + 100)) bad++;
    chk("t2 mem mismatches", bad, 0);
    chk("t2 writes", n_wr, 32);
    chk("t2 frame_done count", n_fd, 1);

    // Early pix_last at address 9
    do_reset();
    for (int i = 0; i < 11; i++) send(8'(i + 50), i == 9);
    idle(3);
    chk("t3 err count", n_err, 1);
    chk("t3 frame_done count", n_fd, 0);
    chk("t3 mem9", mem[9], 59);
    chk("t3 resync mem0", mem[0], 60);

    // Clear request collides with a pixel
    do_reset();
    for (int i = 0; i < 31; i++) send(8'(i + 1), 0);
    @(negedge clk);
    pix_valid = 1; pix_dat = 8'hAA; pix_last = 0; clr_req = 1; clr_dat = 8'h3F;
    @(negedge clk);
    pix_valid = 0; clr_dat = 8'h55;
    @(negedge clk);
    clr_req = 0;
    idle(38);
    chk("t4 busy cycles", n_busy, 32);
    chk("t4 clr_done count", n_cd, 1);
    chk("t4 writes", n_wr, 63);
    bad = 0;
    for (int j = 0; j < NPIX; j++) if (mem[j] !== 8'h3F) bad++;
    chk("t4 fill mismatches", bad, 0);
    send(8'h77, 0);
    idle(2);
    chk("t4 restart mem0", mem[0], 8'h77);

    // Reset during clear at address 15
    do_reset();
    @(negedge clk);
    clr_req = 1; clr_dat = 8'h11;
    @(negedge clk);
    clr_req = 0;
    repeat (15) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle(3);
    chk("t5 writes", n_wr, 15);
    chk("t5 clr_done count", n_cd, 0);
    chk("t5 busy", busy, 0);
    chk("t5 vram_we", vram_we, 0);

`ifdef VIDEO_VRAM_WRITER_STATS_EN
    // Three frames plus one sync error
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NPIX; i++) send(8'(i), i == NPIX - 1);
    for (int i = 0; i < 5; i++) send(8'(i), i == 2);
    idle(3);
    chk("t6 frame_cnt", frame_cnt, 3);
    chk("t6 err_cnt", err_cnt, 1);
    chk("t6 frame_done count", n_fd, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
